spi_regbus_master: RTL
======================

Name: spi_regbus_master

Overview:
- Synthesizable host-side register-access engine. Replaces hand-written byte-sequencing tasks with a parametrised hardware sequencer that drives spi_master's byte interface.
- Frames SPI register transactions as: SYNC byte, {rw, addr}, then data bytes, then pad.
- Generalisations over single-byte accesses: multi-byte register words, burst length up to MAX_BURST words, read-data capture returned as a stream.
- Sits between a command source (soft CPU or test sequencer) and spi_master, on the spi_master pclk domain.

Parameters:
ADDR_W, 7, register address width; header byte = {rw, addr}, so ADDR_W must be 7
DATA_W, 8, register word width; must be a multiple of 8; bytes sent MSB byte first
MAX_BURST, 16, maximum words per transaction; cmd_len field width = clog2(MAX_BURST+1)
SYNC_BYTE, 8'h89, first byte of every frame
PAD_BYTE, 8'h00, trailing byte on writes; dummy byte on reads
TIMEOUT_CYC, 4096, watchdog limit (used only with the optional feature)

Ports:
clk  in  1  pclk of spi_master
rstn_async  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  register start address
cmd_len  in  clog2(MAX_BURST+1)  word count, 1..MAX_BURST
wr_valid  in  1  write word available
wr_ready  out  1  one-cycle pulse when a write word is consumed
wr_data  in  DATA_W  write word
rd_valid  out  1  one-cycle pulse per completed read word
rd_data  out  DATA_W  read word
done  out  1  one-cycle pulse at end of frame
err  out  1  sticky: underflow, bad length or timeout; cleared on next accepted command
di_req  in  1  spi_master next-byte request
di  out  8  byte to spi_master
wren  out  1  byte write enable to spi_master
wr_ack  in  1  spi_master byte accepted
do_valid  in  1  spi_master received-byte pulse
dout  in  8  received byte

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. FSM returns to IDLE; counters cleared.
- Reset is asynchronous and takes effect mid-frame. wren drops immediately.
- Handshake: cmd accepted when cmd_valid && cmd_ready. Accepted command registers addr, len and write flag.
- Length rules: cmd_len = 0 or cmd_len > MAX_BURST → no frame is sent, err = 1, done pulses 1 cycle after accept.
- Frame size: total TX bytes T = 2 + len*DATA_W/8, plus 1 pad byte when writing.
- FSM states: IDLE → LOAD → WAIT_ACK → (next byte: LOAD | all sent: DRAIN) → DONE → IDLE.
- LOAD: waits for a rising edge of di_req (registered edge detect). On that edge, sets di to byte[tx_idx] and sets wren = 1.
- WAIT_ACK: holds wren until wr_ack is sampled high. wren is 0 the following cycle, then tx_idx increments.
- Byte order: byte0 = SYNC_BYTE; byte1 = {cmd_write, addr}.
- Write data bytes: taken from a word register, MSB first. At the LOAD of each word's first byte, wr_ready pulses 1 cycle if wr_valid = 1 and the word is latched.
- Write underflow: if wr_valid = 0 at that point, the word is sent as all PAD_BYTE and err is set. The frame never stalls.
- Reads: all bytes after the header are PAD_BYTE.
- RX path: rx_cnt increments on every do_valid while not IDLE. Bytes with rx_cnt ≥ 2 during a read are shifted into rd_data, MSB first.
- rd_valid pulses on the cycle after the last byte of each word arrives. rd_data is held until the next word completes.
- Write frames discard all received bytes.
- DRAIN: waits until rx_cnt == T, so the last byte has fully shifted. Then DONE pulses done for 1 cycle; cmd_ready returns the cycle after.
- Simultaneous events: do_valid and di_req edge in the same cycle are both processed. cmd_valid during DONE is ignored until IDLE.
- Internal counters wrap only via reset or a new command; tx_idx and rx_cnt are sized for the maximum T.

Optional Feature:
Macro REGBUS_TIMEOUT_EN.
- Defined: a watchdog counter runs while not IDLE and clears on every di_req edge or do_valid. On reaching TIMEOUT_CYC it aborts the frame: wren = 0, err = 1, done pulses, FSM goes to IDLE. Partial read words are discarded with no rd_valid.
- Not defined: no counter is present; the FSM waits indefinitely; TIMEOUT_CYC is unused.

Test Plan:
- Write addr 0x24, len 1, data 0x23, DATA_W = 8 → SPI bytes 89, A4, 23, 00; one wr_ready pulse; done after the 4th do_valid; err = 0.
- Read addr 0x24 after that write, with the slave model returning 0x23 → bytes 89, 24, 00; one rd_valid with rd_data = 0x23.
- DATA_W = 16, read len 3 at addr 0x10, slave returns 0x1234, 0x5678, 0x9ABC → 8 TX bytes; three rd_valid pulses with those values in order.
- Write len 2 with wr_valid low for the second word → second word sent as 00 00; err = 1; done still pulses; next accepted command clears err.
- rstn_async asserted while in WAIT_ACK mid-frame → wren = 0 and cmd_ready = 1 immediately; a new write after release is framed correctly.
- With REGBUS_TIMEOUT_EN, TIMEOUT_CYC = 64, and di_req held low after the header → abort at cycle 64; err = 1; done pulses; no rd_valid.

Source files
------------

// File: rtl/spi_regbus_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : spi_regbus_master                                             |
// | Purpose  : Register-access sequencer driving spi_master's byte port.     |
// |            Frame = SYNC, {rw,addr}, data words MSB byte first, pad.      |
// |            Read bytes after the header are returned as a word stream.    |
// | Options  : REGBUS_TIMEOUT_EN - watchdog aborts a stalled frame after     |
// |            TIMEOUT_CYC cycles without a di_req edge or do_valid.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module spi_regbus_master #(
    parameter int         ADDR_W      = 7,
    parameter int         DATA_W      = 8,
    parameter int         MAX_BURST   = 16,
    parameter logic [7:0] SYNC_BYTE   = 8'h89,
    parameter logic [7:0] PAD_BYTE    = 8'h00,
    parameter int         TIMEOUT_CYC = 4096,
    localparam int        LEN_W       = $clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              rstn_async,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    input  logic              di_req,
    output logic [7:0]        di,
    output logic              wren,
    input  logic              wr_ack,
    input  logic              do_valid,
    input  logic [7:0]        dout
);

    localparam int                NB       = DATA_W / 8;
    localparam int                T_MAX    = 3 + MAX_BURST * NB;
    localparam int                CNT_W    = $clog2(T_MAX + 1);
    localparam logic [DATA_W-1:0] PAD_WORD = {NB{PAD_BYTE}};

    // Reject parameter sets the frame format cannot represent
    generate
        if (ADDR_W != 7 || (DATA_W % 8) != 0 || DATA_W < 8 || MAX_BURST < 1 || TIMEOUT_CYC < 2) begin : g_param_check
            $error("spi_regbus_master: illegal parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_DRAIN    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                di_req_q;
    logic [CNT_W-1:0]    tx_idx_q, tx_idx_d;
    logic [CNT_W-1:0]    tx_byte_q, tx_byte_d;
    logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0]    rx_byte_q, rx_byte_d;
    logic [CNT_W-1:0]    tot_q, tot_d;
    logic [CNT_W-1:0]    data_end_q, data_end_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wsh_q, wsh_d;
    logic [DATA_W-1:0]   rsh_q, rsh_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                wren_q, wren_d;
    logic                err_q, err_d;
    logic [7:0]          di_q, di_d;

    logic                w_edge;
    logic                w_bad_len;
    logic                w_data_byte;
    logic                w_capture;
    logic                w_wr_ready;
    logic [CNT_W-1:0]    w_data_end;
    logic [DATA_W+7:0]   w_rcat;
    logic [DATA_W-1:0]   w_word;

`ifdef REGBUS_TIMEOUT_EN
    localparam int       WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]     wdog_q, wdog_d;
`endif

    assign w_edge      = di_req & ~di_req_q;
    assign w_bad_len   = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_BURST));
    assign w_data_end  = CNT_W'(2) + CNT_W'(cmd_len) * CNT_W'(NB);
    // Current TX byte lies inside the data-word region of the frame
    assign w_data_byte = (tx_idx_q >= CNT_W'(2)) && (tx_idx_q < data_end_q);
    // Received byte belongs to a read word (header echo and late strays ignored)
    assign w_capture   = !write_q && (state_q == S_LOAD || state_q == S_WAIT_ACK || state_q == S_DRAIN)
                         && (rx_cnt_q >= CNT_W'(2)) && (rx_cnt_q < tot_q);
    assign w_rcat      = {rsh_q, dout};

    assign cmd_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign wr_ready  = w_wr_ready;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign err       = err_q;
    assign di        = di_q;
    assign wren      = wren_q;

    // Next-state, byte sequencing and RX word assembly
    always_comb begin
        state_d    = state_q;
        tx_idx_d   = tx_idx_q;
        tx_byte_d  = tx_byte_q;
        rx_cnt_d   = rx_cnt_q;
        rx_byte_d  = rx_byte_q;
        tot_d      = tot_q;
        data_end_d = data_end_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wsh_d      = wsh_q;
        rsh_d      = rsh_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wren_d     = wren_q;
        err_d      = err_q;
        di_d       = di_q;
        w_wr_ready = 1'b0;
        w_word     = PAD_WORD;
`ifdef REGBUS_TIMEOUT_EN
        wdog_d     = wdog_q;
`endif

        // RX runs independently of the TX state so same-cycle events both land
        if (do_valid && state_q != S_IDLE && rx_cnt_q != '1) begin
            rx_cnt_d = rx_cnt_q + 1'b1;
            if (w_capture) begin
                rsh_d = w_rcat[DATA_W-1:0];
                if (rx_byte_q == CNT_W'(NB - 1)) begin
                    rx_byte_d  = '0;
                    rd_data_d  = w_rcat[DATA_W-1:0];
                    rd_valid_d = 1'b1;
                end else begin
                    rx_byte_d = rx_byte_q + 1'b1;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    write_d    = cmd_write;
                    addr_d     = cmd_addr;
                    data_end_d = w_data_end;
                    tot_d      = w_data_end + CNT_W'(cmd_write);
                    tx_idx_d   = '0;
                    tx_byte_d  = '0;
                    rx_cnt_d   = '0;
                    rx_byte_d  = '0;
                    err_d      = w_bad_len;
                    state_d    = w_bad_len ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_edge) begin
                    wren_d  = 1'b1;
                    state_d = S_WAIT_ACK;
                    if (tx_idx_q == '0) begin
                        di_d = SYNC_BYTE;
                    end else if (tx_idx_q == CNT_W'(1)) begin
                        di_d = {write_q, addr_q};
                    end else if (write_q && w_data_byte) begin
                        // First byte of a word consumes the write stream; an
                        // empty stream substitutes pad bytes so the frame never stalls
                        if (tx_byte_q == '0) begin
                            if (wr_valid) begin
                                w_wr_ready = 1'b1;
                                w_word     = wr_data;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else begin
                            w_word = wsh_q;
                        end
                        di_d  = w_word[DATA_W-1 -: 8];
                        wsh_d = w_word << 8;
                    end else begin
                        di_d = PAD_BYTE;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (wr_ack) begin
                    wren_d   = 1'b0;
                    tx_idx_d = tx_idx_q + 1'b1;
                    if (w_data_byte) begin
                        tx_byte_d = (tx_byte_q == CNT_W'(NB - 1)) ? '0 : tx_byte_q + 1'b1;
                    end
                    state_d = (tx_idx_q + 1'b1 >= tot_q) ? S_DRAIN : S_LOAD;
                end
            end
            S_DRAIN: begin
                if (rx_cnt_q >= tot_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef REGBUS_TIMEOUT_EN
        if (state_q == S_IDLE || state_q == S_DONE || w_edge || do_valid) begin
            wdog_d = '0;
        end else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
            wdog_d  = '0;
            wren_d  = 1'b0;
            err_d   = 1'b1;
            state_d = S_DONE;
        end else begin
            wdog_d = wdog_q + 1'b1;
        end
`endif
    end

    // State and datapath registers; reset drops wren without waiting for a clock
    always_ff @(posedge clk or negedge rstn_async) begin
        if (!rstn_async) begin
            state_q    <= S_IDLE;
            di_req_q   <= 1'b0;
            tx_idx_q   <= '0;
            tx_byte_q  <= '0;
            rx_cnt_q   <= '0;
            rx_byte_q  <= '0;
            tot_q      <= '0;
            data_end_q <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wsh_q      <= '0;
            rsh_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wren_q     <= 1'b0;
            err_q      <= 1'b0;
            di_q       <= '0;
`ifdef REGBUS_TIMEOUT_EN
            wdog_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            di_req_q   <= di_req;
            tx_idx_q   <= tx_idx_d;
            tx_byte_q  <= tx_byte_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_byte_q  <= rx_byte_d;
            tot_q      <= tot_d;
            data_end_q <= data_end_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wsh_q      <= wsh_d;
            rsh_q      <= rsh_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wren_q     <= wren_d;
            err_q      <= err_d;
            di_q       <= di_d;
`ifdef REGBUS_TIMEOUT_EN
            wdog_q     <= wdog_d;
`endif
        end
    end

endmodule
`default_nettype wire
